// File: rtl/alu_datapath_pkg.sv
// Shared encodings for the add/subtract/multiply datapath: Y-operand selects,
// load destinations and the default operand width.
package alu_datapath_pkg;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      Y_B   = 2'd0,
      Y_SR  = 2'd1,
      Y_NSR = 2'd2,
      Y_ACC = 2'd3
   } y_sel_e;

   typedef enum logic [1:0] {
      DST_SR       = 2'd0,
      DST_ACC      = 2'd1,
      DST_MUL_INIT = 2'd2,
      DST_NONE     = 2'd3
   } dst_e;
endpackage

// File: rtl/alu_dp_core.sv
// Combinational ALU slice: X/Y operand muxes, carry-in, adder and pass/sum select.
// ALU_DATAPATH_FLAGS_EN adds the signed-overflow output.
module alu_dp_core
   import alu_datapath_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a_reg,
   input  logic [WIDTH-1:0] b_reg,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic             alu_inp_sel_1,
   input  logic [1:0]       alu_inp_sel_2,
   input  logic             alu_out_sel,
   output logic [WIDTH:0]   alu_res
`ifdef ALU_DATAPATH_FLAGS_EN
   ,
   output logic             ovf
`endif
);
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic [WIDTH:0]   sum;

   always_comb begin
      x = alu_inp_sel_1 ? '0 : a_reg;
      y = b_reg;
      case (y_sel_e'(alu_inp_sel_2))
         Y_B:     y = b_reg;
         Y_SR:    y = sr;
         Y_NSR:   y = ~sr;
         Y_ACC:   y = acc_lo;
         default: y = b_reg;
      endcase
   end

   // Inverted SR with carry-in forms the two's complement negation.
   assign cin     = (alu_inp_sel_2 == Y_NSR);
   assign sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
   assign alu_res = alu_out_sel ? sum : {1'b0, y};

`ifdef ALU_DATAPATH_FLAGS_EN
   assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
`endif
endmodule

// File: rtl/alu_datapath.sv
// Register side of the arithmetic datapath: operands, accumulator, multiplier
// shift register and iteration counter. ALU_DATAPATH_FLAGS_EN adds zero/overflow flags.
module alu_datapath
   import alu_datapath_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   input  logic               load_operands,
   input  logic               alu_inp_sel_1,
   input  logic [1:0]         alu_inp_sel_2,
   input  logic               alu_out_sel,
   input  logic [1:0]         shift_inp_sel,
   input  logic               load_shift_reg,
   input  logic               shift,
   input  logic               clear,
   output logic               shift_reg_out,
   output logic               count_ed_0,
   output logic [WIDTH:0]     acc_q,
   output logic [WIDTH-1:0]   sr_q,
   output logic [2*WIDTH-1:0] result
`ifdef ALU_DATAPATH_FLAGS_EN
   ,
   output logic               flag_zero,
   output logic               flag_ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sr;
   logic [WIDTH:0]   acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   alu_res;
`ifdef ALU_DATAPATH_FLAGS_EN
   logic             ovf;
`endif

   alu_dp_core #(.WIDTH(WIDTH)) u_core (
      .a_reg         (a_reg),
      .b_reg         (b_reg),
      .sr            (sr),
      .acc_lo        (acc[WIDTH-1:0]),
      .alu_inp_sel_1 (alu_inp_sel_1),
      .alu_inp_sel_2 (alu_inp_sel_2),
      .alu_out_sel   (alu_out_sel),
      .alu_res       (alu_res)
`ifdef ALU_DATAPATH_FLAGS_EN
      ,
      .ovf           (ovf)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sr        <= '0;
         acc       <= '0;
         cnt       <= '0;
`ifdef ALU_DATAPATH_FLAGS_EN
         flag_zero <= 1'b0;
         flag_ovf  <= 1'b0;
`endif
      end else begin
         // Operand capture sits outside the clear/load/shift priority chain.
         if (load_operands) begin
            a_reg <= operand_a;
            b_reg <= operand_b;
         end
         if (clear) begin
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef ALU_DATAPATH_FLAGS_EN
            flag_zero <= 1'b0;
            flag_ovf  <= 1'b0;
`endif
         end else if (load_shift_reg) begin
            case (dst_e'(shift_inp_sel))
               DST_SR: sr <= alu_res[WIDTH-1:0];
               DST_ACC: begin
                  acc       <= alu_res;
`ifdef ALU_DATAPATH_FLAGS_EN
                  flag_zero <= (alu_res[WIDTH-1:0] == '0);
                  flag_ovf  <= ovf;
`endif
               end
               DST_MUL_INIT: begin
                  sr  <= b_reg;
                  acc <= '0;
                  cnt <= CW'(WIDTH);
               end
               default: ;
            endcase
         end else if (shift) begin
            sr  <= {acc[0], sr[WIDTH-1:1]};
            acc <= {1'b0, acc[WIDTH:1]};
            cnt <= (cnt == '0) ? cnt : cnt - CW'(1);
         end
      end
   end

   assign shift_reg_out = sr[0];
   assign count_ed_0    = (cnt == '0);
   assign acc_q         = acc;
   assign sr_q          = sr;
   assign result        = {acc[WIDTH-1:0], sr};
endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath (WIDTH=8): directed sequences push expected
// state into a queue; a negedge monitor pops and compares.
module tb_alu_datapath;
   import alu_datapath_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  operand_a = '0;
   logic [7:0]  operand_b = '0;
   logic        load_operands = 1'b0;
   logic        alu_inp_sel_1 = 1'b0;
   logic [1:0]  alu_inp_sel_2 = '0;
   logic        alu_out_sel = 1'b0;
   logic [1:0]  shift_inp_sel = '0;
   logic        load_shift_reg = 1'b0;
   logic        shift = 1'b0;
   logic        clear = 1'b0;
   logic        shift_reg_out;
   logic        count_ed_0;
   logic [8:0]  acc_q;
   logic [7:0]  sr_q;
   logic [15:0] result;
`ifdef ALU_DATAPATH_FLAGS_EN
   logic        flag_zero;
   logic        flag_ovf;
`endif

   alu_datapath #(.WIDTH(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .load_operands  (load_operands),
      .alu_inp_sel_1  (alu_inp_sel_1),
      .alu_inp_sel_2  (alu_inp_sel_2),
      .alu_out_sel    (alu_out_sel),
      .shift_inp_sel  (shift_inp_sel),
      .load_shift_reg (load_shift_reg),
      .shift          (shift),
      .clear          (clear),
      .shift_reg_out  (shift_reg_out),
      .count_ed_0     (count_ed_0),
      .acc_q          (acc_q),
      .sr_q           (sr_q),
      .result         (result)
`ifdef ALU_DATAPATH_FLAGS_EN
      ,
      .flag_zero      (flag_zero),
      .flag_ovf       (flag_ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       full;
      logic [8:0] acc;
      logic [7:0] sr;
      logic       cnt0;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, ex);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         mon_e = q.pop_front();
         if (mon_e.full) begin
            cmp({mon_e.name, ".acc_q"}, 32'(acc_q), 32'(mon_e.acc));
            cmp({mon_e.name, ".sr_q"}, 32'(sr_q), 32'(mon_e.sr));
            cmp({mon_e.name, ".result"}, 32'(result), 32'({mon_e.acc[7:0], mon_e.sr}));
            cmp({mon_e.name, ".shift_reg_out"}, 32'(shift_reg_out), 32'(mon_e.sr[0]));
         end
         cmp({mon_e.name, ".count_ed_0"}, 32'(count_ed_0), 32'(mon_e.cnt0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      load_operands  = 1'b0;
      load_shift_reg = 1'b0;
      shift          = 1'b0;
      clear          = 1'b0;
      reset          = 1'b0;
   endtask

   task automatic expf(input string n, input logic [8:0] a, input logic [7:0] s, input logic c);
      q.push_back('{n, 1'b1, a, s, c});
   endtask

   task automatic expc(input string n, input logic c);
      q.push_back('{n, 1'b0, 9'h0, 8'h0, c});
   endtask

   task automatic ops(input logic [7:0] a, input logic [7:0] b);
      operand_a     = a;
      operand_b     = b;
      load_operands = 1'b1;
      tick();
   endtask

   task automatic alu(input logic s1, input logic [1:0] s2, input logic os, input logic [1:0] dst);
      alu_inp_sel_1  = s1;
      alu_inp_sel_2  = s2;
      alu_out_sel    = os;
      shift_inp_sel  = dst;
      load_shift_reg = 1'b1;
      tick();
   endtask

   // One multiply iteration driven from the bench's own copy of the multiplier.
   task automatic mul_iter(input logic [7:0] b, input int i);
      if (b[i]) alu(1'b0, Y_ACC, 1'b1, DST_ACC);
      shift = 1'b1;
      tick();
   endtask

   task automatic multiply(input string n, input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] acc_e, input logic [7:0] sr_e);
      ops(a, b);
      alu(1'b0, Y_B, 1'b0, DST_MUL_INIT);
      expf({n, " init"}, 9'h0, b, 1'b0);
      for (int i = 0; i < 8; i++) begin
         mul_iter(b, i);
         expc($sformatf("%s cnt%0d", n, i), (i == 7));
      end
      expf({n, " product"}, acc_e, sr_e, 1'b1);
   endtask

   initial begin
      #1;
      reset = 1'b1;
      tick();
      expf("por", 9'h0, 8'h0, 1'b1);

      ops(8'd200, 8'd100);
      alu(1'b0, Y_B, 1'b0, DST_MUL_INIT);
      expf("pre_reset", 9'h0, 8'd100, 1'b0);
      reset = 1'b1;
      tick();
      expf("reset", 9'h0, 8'h0, 1'b1);

      ops(8'd200, 8'd100);
      alu(1'b0, Y_B, 1'b1, DST_ACC);
      expf("add", 9'h12C, 8'h0, 1'b1);

      ops(8'd50, 8'd20);
      alu(1'b0, Y_B, 1'b0, DST_SR);
      expf("sub1 pass", 9'h12C, 8'd20, 1'b1);
      alu(1'b1, Y_NSR, 1'b1, DST_SR);
      expf("sub1 neg", 9'h12C, 8'hEC, 1'b1);
      alu(1'b0, Y_SR, 1'b1, DST_ACC);
      expf("sub1 sum", 9'h11E, 8'hEC, 1'b1);

      ops(8'd20, 8'd50);
      alu(1'b0, Y_B, 1'b0, DST_SR);
      expf("sub2 pass", 9'h11E, 8'd50, 1'b1);
      alu(1'b1, Y_NSR, 1'b1, DST_SR);
      expf("sub2 neg", 9'h11E, 8'hCE, 1'b1);
      alu(1'b0, Y_SR, 1'b1, DST_ACC);
      expf("sub2 sum", 9'h0E2, 8'hCE, 1'b1);

      multiply("mul13x11", 8'd13, 8'd11, 9'h000, 8'h8F);
      multiply("mul255x255", 8'd255, 8'd255, 9'h0FE, 8'h01);

      ops(8'd200, 8'd100);
      clear          = 1'b1;
      shift_inp_sel  = DST_MUL_INIT;
      load_shift_reg = 1'b1;
      tick();
      expf("clear_over_load", 9'h0, 8'h0, 1'b1);

      alu(1'b0, Y_B, 1'b0, DST_MUL_INIT);
      expf("init2", 9'h0, 8'h64, 1'b0);
      alu_inp_sel_1  = 1'b0;
      alu_inp_sel_2  = Y_B;
      alu_out_sel    = 1'b0;
      shift_inp_sel  = DST_ACC;
      load_shift_reg = 1'b1;
      shift          = 1'b1;
      tick();
      expf("load_over_shift", 9'h064, 8'h64, 1'b0);

      clear = 1'b1;
      tick();
      expf("clear", 9'h0, 8'h0, 1'b1);
      alu(1'b0, Y_B, 1'b0, DST_SR);
      expf("sr_load", 9'h0, 8'h64, 1'b1);
      shift = 1'b1;
      tick();
      expf("shift_cnt0 a", 9'h0, 8'h32, 1'b1);
      shift = 1'b1;
      tick();
      expf("shift_cnt0 b", 9'h0, 8'h19, 1'b1);

      ops(8'd13, 8'd11);
      alu(1'b0, Y_B, 1'b0, DST_MUL_INIT);
      for (int i = 0; i < 4; i++) mul_iter(8'd11, i);
      expc("mid_mul busy", 1'b0);
      reset          = 1'b1;
      shift          = 1'b1;
      shift_inp_sel  = DST_ACC;
      load_shift_reg = 1'b1;
      tick();
      expf("mid_mul reset", 9'h0, 8'h0, 1'b1);
      alu(1'b0, Y_B, 1'b1, DST_ACC);
      expf("ab_zero_after_reset", 9'h0, 8'h0, 1'b1);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
